joy_gun_accum: RTL and testbench
================================

JOY_GUN_ACCUM -- requirements
Module: joy_gun_accum

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of independent player channels.
REQ-002 SHALL have parameter W, default 6: position width per axis, in bits.
REQ-003 SHALL have parameter DIV, default 3, range 1..31: number of step events per move while a direction is held.
REQ-004 SHALL have parameter CENTER, default 2**(W-1): value loaded by reset and by recenter.
REQ-005 SHALL have parameter ACC_MOVES, default 4: consecutive moves per acceleration level; used only when the REQ-027 macro is defined.
REQ-006 clk_sys  in  1  single core clock; all logic on its rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 tick  in  1  slow level strobe (4 ms counter bit); only its rising edge is used.
REQ-009 joy_left, joy_right, joy_up, joy_down  in  N_CH each  active-high directions; bit c belongs to channel c.
REQ-010 recenter  in  N_CH  per-channel request to return to CENTER.
REQ-011 gun_h, gun_v  out  N_CH*W  packed positions; channel c occupies bits [c*W +: W].
REQ-012 moving  out  N_CH  high while channel c has a valid direction held on either axis.

Function
REQ-013 SHALL register tick into tick_r every cycle; step = tick & ~tick_r, asserted for exactly one cycle per rising edge.
REQ-014 A tick held high for many cycles SHALL produce one step only.
REQ-015 Each channel/axis SHALL hold an independent divider counter div of ceil(log2(DIV+1)) bits.
REQ-016 Axis direction is valid when exactly one of its pair is held; left+right or up+down together SHALL be treated as none held.
REQ-017 On step with a valid direction: if div==DIV-1 then div<=0 and a move occurs; otherwise div<=div+1.
REQ-018 On step with no valid direction: div<=0 and the acceleration level for that axis <=0.
REQ-019 Moves: left decrements gun_h; right increments gun_h; up decrements gun_v; down increments gun_v; each by the current step size.
REQ-020 Arithmetic SHALL be computed in W+1 bits and saturate to 0 on underflow and to 2**W-1 on overflow; no wrap-around.
REQ-021 Latency: a step in cycle k SHALL be visible on gun_h/gun_v in cycle k+1; the first move occurs on the DIV-th step after the press.
REQ-022 recenter[c] SHALL, in the next cycle, load CENTER into both axes of c and clear its dividers and acceleration; it takes priority over a simultaneous move.
REQ-023 moving SHALL be combinational from the direction inputs per REQ-016.
REQ-024 Channels SHALL never interact; no state changes in cycles without step except via recenter or reset.

Reset
REQ-025 While reset is high, at each clock: gun_h=gun_v=CENTER for every channel; all div, acceleration and tick_r cleared; reset overrides recenter and step.
REQ-026 Reset asserted mid-hold SHALL discard the partial divider count; the first move after release of reset requires DIV fresh steps.

Configuration
REQ-027 Macro JOY_GUN_ACCEL_EN defined: per-axis level 0..2 increments after every ACC_MOVES consecutive moves in one direction; step size = 1<<level; level clears on release, on direction reversal, on recenter and on reset.
REQ-028 Macro JOY_GUN_ACCEL_EN undefined: step size is fixed at 1; ACC_MOVES is ignored; no acceleration registers are synthesised.

Verification (W=6, DIV=3, CENTER=32, N_CH=2)
REQ-029 Pulse reset -> gun_h=gun_v=32 on both channels; moving=0.
REQ-030 Hold joy_right[0] for 6 tick edges -> ch0 gun_h goes to 33 after edge 3 and 34 after edge 6; ch1 stays 32.
REQ-031 Set ch0 gun_h=1, hold left for 9 edges -> 0 after edge 3, stays 0 afterwards. Hold right from 62 -> 63, stays 63.
REQ-032 Hold tick high for 10 cycles with down held, DIV=1 -> gun_v increments exactly once. Left+right held -> no change and moving=0.
REQ-033 recenter[1] in the same cycle as a move-producing step on ch1 -> ch1 reads 32 next cycle; ch0 still moves.
REQ-034 With JOY_GUN_ACCEL_EN and ACC_MOVES=4, hold down with DIV=1 -> gun_v sequence 33,34,35,36,38,40,42,44,48,52,...,63 (saturated). Without the macro -> increments of 1 only.

Source files
------------

// File: rtl/joy_gun_accum.sv
// joy_gun_accum: per-channel light-gun crosshair accumulator. Held joystick
// directions nudge a saturating X/Y position once every DIV rising edges
// of a slow tick strobe.
// Ports: clk_sys/reset (sync, active-high), tick (slow level strobe),
//   joy_left/right/up/down[N_CH] directions, recenter[N_CH] load CENTER,
//   gun_h/gun_v[N_CH*W] packed positions, moving[N_CH] direction held.
// Option: define JOY_GUN_ACCEL_EN for per-axis step acceleration (1,2,4)
//   after every ACC_MOVES consecutive moves in one direction.
module joy_gun_accum #(
  parameter int N_CH      = 2,
  parameter int W         = 6,
  parameter int DIV       = 3,
  parameter int CENTER    = 2**(W-1),
  parameter int ACC_MOVES = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              tick,
  input  logic [N_CH-1:0]   joy_left,
  input  logic [N_CH-1:0]   joy_right,
  input  logic [N_CH-1:0]   joy_up,
  input  logic [N_CH-1:0]   joy_down,
  input  logic [N_CH-1:0]   recenter,
  output logic [N_CH*W-1:0] gun_h,
  output logic [N_CH*W-1:0] gun_v,
  output logic [N_CH-1:0]   moving
);

  localparam int DW = $clog2(DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0] D_ONE    = DW'(1);
  localparam logic [W-1:0]  CTR      = W'(CENTER);
  localparam logic [W:0]    ONE      = (W+1)'(1);

  logic tick_q;
  logic step;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick;
    end
  end

  // One-cycle strobe per rising edge of the slow tick level.
  assign step = tick & ~tick_q;

  // Opposing directions pressed together cancel out.
  assign moving = (joy_left ^ joy_right) | (joy_up ^ joy_down);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    for (genvar a = 0; a < 2; a++) begin : g_ax
      logic          dn;
      logic          inc;
      logic          vld;
      logic          mv;
      logic [DW-1:0] div_q;
      logic [DW-1:0] div_d;
      logic [W-1:0]  pos_q;
      logic [W-1:0]  pos_d;
      logic [W:0]    size;
      logic [W:0]    sum;
      logic [W:0]    dif;

      // Axis 0 is horizontal (left/right), axis 1 vertical (up/down).
      assign dn  = (a == 0) ? joy_left[c]  : joy_up[c];
      assign inc = (a == 0) ? joy_right[c] : joy_down[c];
      assign vld = dn ^ inc;
      assign mv  = step & vld & (div_q == DIV_LAST);

      // One extra bit catches overflow/underflow for saturation.
      assign sum = {1'b0, pos_q} + size;
      assign dif = {1'b0, pos_q} - size;

      always_comb begin
        pos_d = pos_q;
        div_d = div_q;
        if (step) begin
          if (!vld) begin
            div_d = '0;
          end else if (div_q == DIV_LAST) begin
            div_d = '0;
            if (inc) begin
              pos_d = sum[W] ? {W{1'b1}} : sum[W-1:0];
            end else begin
              pos_d = dif[W] ? '0 : dif[W-1:0];
            end
          end else begin
            div_d = div_q + D_ONE;
          end
        end
      end

      always_ff @(posedge clk_sys) begin
        if (reset || recenter[c]) begin
          pos_q <= CTR;
          div_q <= '0;
        end else begin
          pos_q <= pos_d;
          div_q <= div_d;
        end
      end

`ifdef JOY_GUN_ACCEL_EN
      localparam int CW = (ACC_MOVES > 1) ? $clog2(ACC_MOVES) : 1;
      localparam logic [CW-1:0] ACC_LAST = CW'(ACC_MOVES - 1);
      localparam logic [CW-1:0] C_ONE    = CW'(1);

      logic [1:0]    lvl_q;
      logic [1:0]    lvl_d;
      logic [1:0]    lvl_eff;
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;
      logic [CW-1:0] cnt_eff;
      logic          dir_q;
      logic          dir_d;
      logic          rev;

      // A reversal drops back to unit steps before this step's move.
      assign rev     = step & vld & (inc != dir_q);
      assign lvl_eff = rev ? 2'd0 : lvl_q;
      assign cnt_eff = rev ? '0 : cnt_q;
      assign size    = ONE << lvl_eff;

      always_comb begin
        lvl_d = lvl_q;
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (step) begin
          if (!vld) begin
            lvl_d = 2'd0;
            cnt_d = '0;
          end else begin
            dir_d = inc;
            lvl_d = lvl_eff;
            cnt_d = cnt_eff;
            if (mv) begin
              if (cnt_eff == ACC_LAST) begin
                cnt_d = '0;
                if (lvl_eff != 2'd2) begin
                  lvl_d = lvl_eff + 2'd1;
                end
              end else begin
                cnt_d = cnt_eff + C_ONE;
              end
            end
          end
        end
      end

      always_ff @(posedge clk_sys) begin
        if (reset || recenter[c]) begin
          lvl_q <= 2'd0;
          cnt_q <= '0;
          dir_q <= 1'b0;
        end else begin
          lvl_q <= lvl_d;
          cnt_q <= cnt_d;
          dir_q <= dir_d;
        end
      end
`else
      assign size = ONE;
`endif

      if (a == 0) begin : g_h
        assign gun_h[c*W +: W] = pos_q;
      end else begin : g_v
        assign gun_v[c*W +: W] = pos_q;
      end
    end
  end

endmodule

// File: tb/tb_joy_gun_accum.sv
// tb_joy_gun_accum: scoreboard bench for joy_gun_accum with two instances
// (DIV=3 and DIV=1) sharing stimulus, checked against a behavioural model.
module tb_joy_gun_accum;

`ifdef JOY_GUN_ACCEL_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        tick;
  logic [1:0]  jl, jr, ju, jd, rc;
  logic [11:0] ha, va, hb, vb;
  logic [1:0]  ma, mb;

  joy_gun_accum #(
    .N_CH(2), .W(6), .DIV(3), .CENTER(32), .ACC_MOVES(4)
  ) u_a (
    .clk_sys(clk), .reset(reset), .tick(tick),
    .joy_left(jl), .joy_right(jr), .joy_up(ju), .joy_down(jd),
    .recenter(rc), .gun_h(ha), .gun_v(va), .moving(ma)
  );

  joy_gun_accum #(
    .N_CH(2), .W(6), .DIV(1), .CENTER(32), .ACC_MOVES(4)
  ) u_b (
    .clk_sys(clk), .reset(reset), .tick(tick),
    .joy_left(jl), .joy_right(jr), .joy_up(ju), .joy_down(jd),
    .recenter(rc), .gun_h(hb), .gun_v(vb), .moving(mb)
  );

  typedef struct packed {
    logic [11:0] ha, va, hb, vb;
    logic [1:0]  ma, mb;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  // Model state: [instance][channel][axis]
  int divp[2] = '{3, 1};
  int pos[2][2][2];
  int cnt[2][2][2];
  int lev[2][2][2];
  int mvs[2][2][2];
  int dir[2][2][2];
  int tick_r;

  function automatic logic [11:0] pk(int u, int a);
    logic [11:0] r;
    r = '0;
    for (int c = 0; c < 2; c++) r[c*6 +: 6] = 6'(pos[u][c][a]);
    return r;
  endfunction

  task automatic model_edge();
    bit st, n, p;
    int s;
    st = tick && (tick_r == 0);
    for (int u = 0; u < 2; u++)
      for (int c = 0; c < 2; c++)
        for (int a = 0; a < 2; a++) begin
          n = (a == 0) ? jl[c] : ju[c];
          p = (a == 0) ? jr[c] : jd[c];
          if (reset || rc[c]) begin
            pos[u][c][a] = 32; cnt[u][c][a] = 0;
            lev[u][c][a] = 0;  mvs[u][c][a] = 0;
            dir[u][c][a] = 0;
          end else if (st) begin
            if (n == p) begin
              cnt[u][c][a] = 0; lev[u][c][a] = 0; mvs[u][c][a] = 0;
            end else begin
              if (ACC && int'(p) != dir[u][c][a]) begin
                lev[u][c][a] = 0; mvs[u][c][a] = 0;
              end
              dir[u][c][a] = int'(p);
              cnt[u][c][a]++;
              if (cnt[u][c][a] == divp[u]) begin
                cnt[u][c][a] = 0;
                s = ACC ? (1 << lev[u][c][a]) : 1;
                if (p) pos[u][c][a] = (pos[u][c][a] + s > 63) ? 63 : pos[u][c][a] + s;
                else   pos[u][c][a] = (pos[u][c][a] - s < 0) ? 0 : pos[u][c][a] - s;
                if (ACC) begin
                  mvs[u][c][a]++;
                  if (mvs[u][c][a] == 4) begin
                    mvs[u][c][a] = 0;
                    if (lev[u][c][a] < 2) lev[u][c][a]++;
                  end
                end
              end
            end
          end
        end
    tick_r = reset ? 0 : int'(tick);
  endtask

  // Push the outputs expected during this cycle, then advance the model
  // across the coming clock edge.
  task automatic cyc(input bit chk);
    exp_t e;
    if (chk) begin
      e.ha = pk(0, 0); e.va = pk(0, 1);
      e.hb = pk(1, 0); e.vb = pk(1, 1);
      e.ma = (jl ^ jr) | (ju ^ jd);
      e.mb = (jl ^ jr) | (ju ^ jd);
      q.push_back(e);
    end
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1; cyc(1); cyc(1);
      tick = 1'b0; cyc(1); cyc(1);
    end
  endtask

  task automatic chk(input string nm, input logic [11:0] act,
                     input logic [11:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("gun_h_div3", ha, e.ha);
        chk("gun_v_div3", va, e.va);
        chk("gun_h_div1", hb, e.hb);
        chk("gun_v_div1", vb, e.vb);
        chk("moving_div3", {10'd0, ma}, {10'd0, e.ma});
        chk("moving_div1", {10'd0, mb}, {10'd0, e.mb});
      end
    end
  end

  initial begin
    reset = 1'b1; tick = 1'b0;
    jl = '0; jr = '0; ju = '0; jd = '0; rc = '0;
    tick_r = 0;
    @(posedge clk); #1;
    cyc(0);
    cyc(1);
    reset = 1'b0;
    cyc(1); cyc(1);

    jr = 2'b01;
    pulses(6);
    jr = 2'b00; jl = 2'b01;
    pulses(120);
    jl = 2'b00; jr = 2'b01;
    pulses(200);

    jr = 2'b00; jd = 2'b11;
    tick = 1'b1;
    repeat (10) cyc(1);
    tick = 1'b0;
    cyc(1); cyc(1);
    jd = 2'b00;

    jl = 2'b11; jr = 2'b11;
    pulses(4);

    jl = 2'b00; jr = 2'b11;
    pulses(2);
    tick = 1'b1; rc = 2'b10;
    cyc(1);
    rc = 2'b00;
    cyc(1);
    tick = 1'b0;
    cyc(1); cyc(1);

    pulses(2);
    reset = 1'b1; cyc(1);
    reset = 1'b0; cyc(1);
    pulses(4);

    jr = 2'b00;
    rc = 2'b11; cyc(1); rc = 2'b00;
    jd = 2'b11;
    pulses(20);
    jd = 2'b01; ju = 2'b10;
    pulses(6);
    ju = 2'b01; jd = 2'b00;
    pulses(6);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) tick = ~tick;
      if ($urandom_range(0, 24) == 0) {jl, jr, ju, jd} = 8'($urandom);
      rc = ($urandom_range(0, 63) == 0) ? 2'($urandom) : 2'b00;
      reset = ($urandom_range(0, 399) == 0);
      cyc(1);
    end
    reset = 1'b0;

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain got=%0d want=0 entries left", q.size());
    end
    #1;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
